// File: rtl/ap_mult_acc_8b.sv
// ap_mult_acc_8b
// Streaming accumulator that sits behind the 8-bit approximate multiplier.
// It sums the products of one group and returns the sum, the beat count
// and the overflow/truncation flags through a registered valid/ready output.
module ap_mult_acc_8b #(
  parameter int PW        = 16,
  parameter int ACC_W     = 24,
  parameter int CNT_W     = 9,
  parameter int MAX_BEATS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf,
  output logic             out_trunc
);

  // ACC: no result is pending. OUT: a result is waiting for the consumer.
  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  logic [0:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovfSticky;

  logic             w_accept;
  logic             w_consume;
  logic [ACC_W:0]   w_nsum;
  logic             w_ovf;
  logic [ACC_W-1:0] w_satSum;
  logic [CNT_W-1:0] w_ncnt;
  logic             w_hitMax;
  logic             w_close;

  // A new beat fits when nothing is pending, or when the pending result
  // leaves this same cycle. This must not depend on in_valid.
  assign in_ready  = (r_state == ST_ACC) | out_ready;
  assign out_valid = (r_state == ST_OUT);

  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready;

  // One extra bit on the sum exposes the carry. A carry clamps the sum to
  // all-ones. Once the accumulator is all-ones, it stays there, because
  // adding a non-negative value either carries again or adds zero.
  assign w_nsum   = {1'b0, r_acc} + (ACC_W+1)'(in_prod);
  assign w_ovf    = w_nsum[ACC_W];
  assign w_satSum = w_ovf ? {ACC_W{1'b1}} : w_nsum[ACC_W-1:0];

  assign w_ncnt   = r_cnt + 1'b1;
  assign w_hitMax = (w_ncnt == MAX_CNT);
  assign w_close  = in_last | w_hitMax;

  // Handshake FSM and the running group state (sum, count, sticky overflow).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovfSticky <= 1'b0;
    end else begin
      if (w_accept && w_close) begin
        r_state     <= ST_OUT;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovfSticky <= 1'b0;
      end else begin
        if (w_consume) begin
          r_state <= ST_ACC;
        end
        if (w_accept) begin
          r_acc       <= w_satSum;
          r_cnt       <= w_ncnt;
          r_ovfSticky <= r_ovfSticky | w_ovf;
        end
      end
    end
  end

  // Result registers load only on a closing beat. Otherwise they keep the
  // last result, so the data stays stable during back-pressure and after a
  // consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else if (w_accept && w_close) begin
      out_sum   <= w_satSum;
      out_cnt   <= w_ncnt;
      out_ovf   <= r_ovfSticky | w_ovf;
      out_trunc <= ~in_last & w_hitMax;
    end
  end

endmodule

// File: tb/tb_ap_mult_acc_8b.sv
// tb_ap_mult_acc_8b
// Two instances are driven by the same stimulus.
// - dutA uses the default configuration (24-bit sum, 256 beats).
// - dutB is a narrow configuration (16-bit sum, 4 beats). It exercises saturation and truncation.
// A group-level reference model predicts every output of both instances.
module tb_ap_mult_acc_8b;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic [15:0] inProd;
  logic        inLast;
  logic        outReady;

  logic        aReady, aValid, aOvf, aTrunc;
  logic [23:0] aSum;
  logic [8:0]  aCnt;
  logic        bReady, bValid, bOvf, bTrunc;
  logic [15:0] bSum;
  logic [2:0]  bCnt;

  int passCount = 0;
  int totalCount = 0;

  ap_mult_acc_8b dutA (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(aReady),
    .in_prod(inProd), .in_last(inLast), .out_valid(aValid), .out_ready(outReady),
    .out_sum(aSum), .out_cnt(aCnt), .out_ovf(aOvf), .out_trunc(aTrunc)
  );

  ap_mult_acc_8b #(.PW(16), .ACC_W(16), .CNT_W(3), .MAX_BEATS(4)) dutB (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(bReady),
    .in_prod(inProd), .in_last(inLast), .out_valid(bValid), .out_ready(outReady),
    .out_sum(bSum), .out_cnt(bCnt), .out_ovf(bOvf), .out_trunc(bTrunc)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state, one slot per instance (0 = A, 1 = B).
  // The model tracks the exact running total of the group. The reported sum
  // is that total clamped to the maximum value, and overflow means the total
  // went above the maximum.
  longint mTotal[2];
  int     mCnt[2];
  bit     mPend[2];
  longint mSum[2];
  int     mCntOut[2];
  bit     mOvf[2];
  bit     mTrunc[2];
  longint maxVal[2]   = '{64'd16777215, 64'd65535};
  int     maxBeats[2] = '{256, 4};

  task automatic checkOutput(input string name, input longint act, input longint exp);
    totalCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mTotal[k] = 0; mCnt[k] = 0; mPend[k] = 0;
      mSum[k] = 0; mCntOut[k] = 0; mOvf[k] = 0; mTrunc[k] = 0;
    end
  endtask

  task automatic modelStep(input bit v, input longint p, input bit l, input bit r);
    bit ready, consume;
    for (int k = 0; k < 2; k++) begin
      ready   = !mPend[k] || r;
      consume = mPend[k] && r;
      if (v && ready) begin
        mTotal[k] += p;
        mCnt[k]++;
        if (l || mCnt[k] == maxBeats[k]) begin
          mSum[k]    = (mTotal[k] > maxVal[k]) ? maxVal[k] : mTotal[k];
          mCntOut[k] = mCnt[k];
          mOvf[k]    = mTotal[k] > maxVal[k];
          mTrunc[k]  = !l && (mCnt[k] == maxBeats[k]);
          mPend[k]   = 1;
          mTotal[k]  = 0;
          mCnt[k]    = 0;
        end else if (consume) begin
          mPend[k] = 0;
        end
      end else if (consume) begin
        mPend[k] = 0;
      end
    end
  endtask

  task automatic checkModel();
    checkOutput("A.out_valid", aValid, mPend[0]);
    checkOutput("A.out_sum",   aSum,   mSum[0]);
    checkOutput("A.out_cnt",   aCnt,   mCntOut[0]);
    checkOutput("A.out_ovf",   aOvf,   mOvf[0]);
    checkOutput("A.out_trunc", aTrunc, mTrunc[0]);
    checkOutput("B.out_valid", bValid, mPend[1]);
    checkOutput("B.out_sum",   bSum,   mSum[1]);
    checkOutput("B.out_cnt",   bCnt,   mCntOut[1]);
    checkOutput("B.out_ovf",   bOvf,   mOvf[1]);
    checkOutput("B.out_trunc", bTrunc, mTrunc[1]);
  endtask

  // Called shortly after a rising edge. It drives one cycle of inputs,
  // checks the combinational in_ready, advances the model across the next
  // edge, and then checks the registered outputs.
  task automatic applyStimulus(input bit v, input logic [15:0] p, input bit l, input bit r);
    inValid = v; inProd = p; inLast = l; outReady = r;
    #1;
    checkOutput("A.in_ready", aReady, !mPend[0] || r);
    checkOutput("B.in_ready", bReady, !mPend[1] || r);
    modelStep(v, p, l, r);
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic applyReset();
    inValid = 1'b0; inLast = 1'b0; inProd = '0; outReady = 1'b0;
    rstN = 1'b0;
    #1;
    modelReset();
    checkModel();
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  typedef struct {
    bit          v;
    logic [15:0] prod;
    bit          last;
    bit          ordy;
    bit          expValid;
    logic [15:0] expSum;
    logic [2:0]  expCnt;
    bit          expOvf;
    bit          expTrunc;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Hand-computed expectations for dutB (16-bit sum, 4 beats per group).
    tbl[0]  = '{1'b1, 16'd100,  1'b0, 1'b1, 1'b0, 16'd0,   3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'd200,  1'b0, 1'b1, 1'b0, 16'd0,   3'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 16'd300,  1'b1, 1'b1, 1'b1, 16'd600, 3'd3, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 16'd0,    1'b0, 1'b1, 1'b0, 16'd600, 3'd3, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'd600, 3'd3, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, 16'd600, 3'd3, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b1, 16'hFFFF, 3'd3, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 16'd0,    1'b0, 1'b1, 1'b0, 16'hFFFF, 3'd3, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 16'd7,    1'b1, 1'b0, 1'b1, 16'd7,   3'd1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 16'd9,    1'b1, 1'b0, 1'b1, 16'd7,   3'd1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 16'd9,    1'b1, 1'b1, 1'b1, 16'd9,   3'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 16'd0,    1'b0, 1'b1, 1'b0, 16'd9,   3'd1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 16'd10,   1'b0, 1'b1, 1'b0, 16'd9,   3'd1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 16'd10,   1'b0, 1'b1, 1'b0, 16'd9,   3'd1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 16'd10,   1'b0, 1'b1, 1'b0, 16'd9,   3'd1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 16'd10,   1'b0, 1'b1, 1'b1, 16'd40,  3'd4, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 16'd0,    1'b0, 1'b1, 1'b0, 16'd40,  3'd4, 1'b0, 1'b1};

    // Reset state and idle behaviour.
    inValid = 1'b0; inProd = '0; inLast = 1'b0; outReady = 1'b0;
    rstN = 1'b0;
    #1;
    modelReset();
    checkModel();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    checkOutput("rst.A.in_ready", aReady, 1);
    checkOutput("rst.B.in_ready", bReady, 1);
    checkOutput("rst.A.out_valid", aValid, 0);
    checkOutput("rst.A.out_sum", aSum, 0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);

    // Table: basic group, saturation, out_ready ignored in ACC,
    // consume together with a closing beat, and truncation at 4 beats.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].v, tbl[i].prod, tbl[i].last, tbl[i].ordy);
      checkOutput($sformatf("tbl[%0d].B.valid", i), bValid, tbl[i].expValid);
      checkOutput($sformatf("tbl[%0d].B.sum", i),   bSum,   tbl[i].expSum);
      checkOutput($sformatf("tbl[%0d].B.cnt", i),   bCnt,   tbl[i].expCnt);
      checkOutput($sformatf("tbl[%0d].B.ovf", i),   bOvf,   tbl[i].expOvf);
      checkOutput($sformatf("tbl[%0d].B.trunc", i), bTrunc, tbl[i].expTrunc);
    end
    // dutA saw 0xFFFF+2+1 without saturating in 24 bits.
    checkOutput("A.wideNoSat", mOvf[0], 0);

    // Back-pressure: the result stays stable and no beats are taken.
    applyReset();
    applyStimulus(1'b1, 16'd5, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'd77, 1'b1, 1'b0);
      checkOutput("bp.A.sum", aSum, 5);
      checkOutput("bp.B.sum", bSum, 5);
      checkOutput("bp.A.in_ready", aReady, 0);
      checkOutput("bp.A.valid", aValid, 1);
    end
    applyStimulus(1'b1, 16'd3, 1'b0, 1'b1);
    checkOutput("bp.release.A.valid", aValid, 0);
    applyStimulus(1'b1, 16'd4, 1'b1, 1'b1);
    checkOutput("bp.next.A.sum", aSum, 7);
    checkOutput("bp.next.A.cnt", aCnt, 2);

    // Streaming: eight single-beat groups back to back.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b1, 1'b1);
      checkOutput("stream.A.valid", aValid, 1);
      checkOutput("stream.A.sum", aSum, i);
      checkOutput("stream.A.cnt", aCnt, 1);
      checkOutput("stream.B.sum", bSum, i);
    end
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);

    // Reset mid-group: the partial group never produces a result.
    applyStimulus(1'b1, 16'd10, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'd10, 1'b0, 1'b1);
    applyReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
      checkOutput("rstMid.B.valid", bValid, 0);
      checkOutput("rstMid.A.valid", aValid, 0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] p;
      if ($urandom_range(0, 3) == 0) p = 16'hC000 | 16'($urandom_range(0, 16383));
      else p = 16'($urandom_range(0, 4095));
      if (i == 300) applyReset();
      applyStimulus($urandom_range(0, 9) < 7, p, $urandom_range(0, 9) < 2,
                    $urandom_range(0, 9) < 6);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
